// File: rtl/mmio_responder.sv
// mmio_responder: responder end of the CPU's memory-mapped I/O bus.
// Holds the HEX/LEDR/LEDG output registers, synchronises and debounces
// the KEY and SW board inputs, and returns read data one cycle after a load.
// Optional build macro: MMIO_KEY_EDGE_EN adds the sticky KEYEDGE register
// at 0xF0000018 (write-1-to-clear, set wins over clear).
module mmio_responder #(
    parameter int                 DBITS           = 32,
    parameter logic [DBITS-1:0]   ADDR_HEX        = DBITS'(32'hF0000000),
    parameter logic [DBITS-1:0]   ADDR_LEDR       = DBITS'(32'hF0000004),
    parameter logic [DBITS-1:0]   ADDR_LEDG       = DBITS'(32'hF0000008),
    parameter logic [DBITS-1:0]   ADDR_KEY        = DBITS'(32'hF0000010),
    parameter logic [DBITS-1:0]   ADDR_SW         = DBITS'(32'hF0000014),
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 CNT_BITS        = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [DBITS-1:0] wdata,
    output logic             hit,
    output logic [DBITS-1:0] rdata,
    output logic             rdata_valid,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3
);

`ifdef MMIO_KEY_EDGE_EN
    localparam logic [DBITS-1:0] ADDR_KEYEDGE = DBITS'(32'hF0000018);
`endif

    // Input vector: switches in [13:4], keys in [3:0] inverted so that 1 means
    // pressed; this keeps the all-zero reset state equal to "released".
    localparam int NB = 14;
    // The counter value at which the next still-different cycle is the
    // DEBOUNCE_CYCLES-th one, so the debounced value flips on that edge.
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, COUNTING} db_state_e;

    logic [NB-1:0]       raw_in;
    logic [NB-1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]       db_q, db_d;
    db_state_e           state_q [NB];
    db_state_e           state_d [NB];
    logic [CNT_BITS-1:0] cnt_q [NB];
    logic [CNT_BITS-1:0] cnt_d [NB];

    logic [15:0]         hex_q, hex_d;
    logic [9:0]          ledr_q, ledr_d;
    logic [7:0]          ledg_q, ledg_d;
    logic [DBITS-1:0]    rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic [DBITS-1:0]    read_mux;
`ifdef MMIO_KEY_EDGE_EN
    logic [3:0]          keyedge_q, keyedge_d;
    logic [3:0]          key_rise;
`endif
    logic                unused_wdata;

    assign raw_in       = {sw, ~key};
    assign unused_wdata = ^wdata[DBITS-1:16];

    // Active-low seven-segment patterns, segment g on bit 6, a on bit 0.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Per-bit debouncer next state: a change must persist DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted value aborts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    if (sync2_q[i] != db_q[i]) begin
                        state_d[i] = COUNTING;
                        cnt_d[i]   = CNT_BITS'(1);
                    end
                end
                default: begin
                    if (sync2_q[i] == db_q[i]) begin
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        db_d[i]    = sync2_q[i];
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_BITS'(1);
                    end
                end
            endcase
        end
    end

    // Address decode and read-data selection for the mapped registers.
    always_comb begin
        hit      = 1'b1;
        read_mux = '0;
        case (addr)
            ADDR_HEX:     read_mux = DBITS'(hex_q);
            ADDR_LEDR:    read_mux = DBITS'(ledr_q);
            ADDR_LEDG:    read_mux = DBITS'(ledg_q);
            ADDR_KEY:     read_mux = DBITS'(db_q[3:0]);
            ADDR_SW:      read_mux = DBITS'(db_q[13:4]);
`ifdef MMIO_KEY_EDGE_EN
            ADDR_KEYEDGE: read_mux = DBITS'(keyedge_q);
`endif
            default:      hit      = 1'b0;
        endcase
    end

    // Register file next state: stores, registered reads (pre-write value on
    // a same-cycle read+write), and the synchroniser shift.
    always_comb begin
        sync1_d       = raw_in;
        sync2_d       = sync1_q;
        hex_d         = hex_q;
        ledr_d        = ledr_q;
        ledg_d        = ledg_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rd_en;
        if (wr_en && addr == ADDR_HEX)  hex_d  = wdata[15:0];
        if (wr_en && addr == ADDR_LEDR) ledr_d = wdata[9:0];
        if (wr_en && addr == ADDR_LEDG) ledg_d = wdata[7:0];
        if (rd_en) rdata_d = read_mux;
`ifdef MMIO_KEY_EDGE_EN
        key_rise  = db_d[3:0] & ~db_q[3:0];
        keyedge_d = keyedge_q;
        if (wr_en && addr == ADDR_KEYEDGE) keyedge_d = keyedge_q & ~wdata[3:0];
        keyedge_d = keyedge_d | key_rise;
`endif
    end

    // State registers, all cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            db_q          <= '0;
            hex_q         <= '0;
            ledr_q        <= '0;
            ledg_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
`ifdef MMIO_KEY_EDGE_EN
            keyedge_q     <= '0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_q          <= db_d;
            hex_q         <= hex_d;
            ledr_q        <= ledr_d;
            ledg_q        <= ledg_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef MMIO_KEY_EDGE_EN
            keyedge_q     <= keyedge_d;
`endif
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign ledr        = ledr_q;
    assign ledg        = ledg_q;
    assign hex0        = seg7(hex_q[3:0]);
    assign hex1        = seg7(hex_q[7:4]);
    assign hex2        = seg7(hex_q[11:8]);
    assign hex3        = seg7(hex_q[15:12]);

endmodule

// File: tb/tb_mmio_responder.sv
// Directed testbench for mmio_responder with DEBOUNCE_CYCLES=4.
// Honours MMIO_KEY_EDGE_EN to exercise or rule out the KEYEDGE register.
module tb_mmio_responder;

    localparam logic [31:0] A_HEX     = 32'hF0000000;
    localparam logic [31:0] A_LEDR    = 32'hF0000004;
    localparam logic [31:0] A_LEDG    = 32'hF0000008;
    localparam logic [31:0] A_KEY     = 32'hF0000010;
    localparam logic [31:0] A_SW      = 32'hF0000014;
    localparam logic [31:0] A_KEYEDGE = 32'hF0000018;
    localparam logic [31:0] A_NONE    = 32'hF0000020;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int vectors;
    int miscompares;

    mmio_responder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .hit(hit), .rdata(rdata), .rdata_valid(rdata_valid),
        .key(key), .sw(sw), .ledr(ledr), .ledg(ledg),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    // Free-running clock; inputs change and outputs are sampled on negedges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One bus cycle starting at a negedge; strobes drop after the posedge.
    task automatic apply_stimulus(input logic w, input logic r,
                                  input logic [31:0] a, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Single comparison point; counts vectors and miscompares.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational decode check, realigned to the next negedge afterwards.
    task automatic check_hit(input string tag, input logic [31:0] a, input logic exp);
        addr = a;
        #1;
        check_output(tag, {31'b0, hit}, {31'b0, exp});
        @(negedge clk);
    endtask

    // Directed sequence following the block's test plan.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        addr  = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        key   = 4'hF;
        sw    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        $display("[TB] reset state");
        check_output("rst_hex0", 32'(hex0), 32'h40);
        check_output("rst_hex1", 32'(hex1), 32'h40);
        check_output("rst_hex2", 32'(hex2), 32'h40);
        check_output("rst_hex3", 32'(hex3), 32'h40);
        check_output("rst_ledr", 32'(ledr), 32'h0);
        check_output("rst_ledg", 32'(ledg), 32'h0);
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_valid", 32'(rdata_valid), 32'h0);

        $display("[TB] HEX write/read");
        apply_stimulus(1'b1, 1'b0, A_HEX, 32'hFFFF_1A2F);
        check_output("hex0_F", 32'(hex0), 32'h0E);
        check_output("hex1_2", 32'(hex1), 32'h24);
        check_output("hex2_A", 32'(hex2), 32'h08);
        check_output("hex3_1", 32'(hex3), 32'h79);
        apply_stimulus(1'b0, 1'b1, A_HEX, '0);
        check_output("hex_read", rdata, 32'h0000_1A2F);
        check_output("hex_read_valid", 32'(rdata_valid), 32'h1);
        apply_stimulus(1'b0, 1'b0, A_HEX, '0);
        check_output("valid_drops", 32'(rdata_valid), 32'h0);
        check_output("rdata_holds", rdata, 32'h0000_1A2F);

        $display("[TB] LED write/read");
        apply_stimulus(1'b1, 1'b0, A_LEDR, 32'hFFFF_FFFF);
        check_output("ledr_write", 32'(ledr), 32'h3FF);
        apply_stimulus(1'b1, 1'b0, A_LEDG, 32'hFFFF_FFFF);
        check_output("ledg_write", 32'(ledg), 32'hFF);
        apply_stimulus(1'b0, 1'b1, A_LEDR, '0);
        check_output("ledr_read", rdata, 32'h3FF);
        apply_stimulus(1'b0, 1'b1, A_LEDG, '0);
        check_output("ledg_read_b2b", rdata, 32'hFF);
        check_output("ledg_read_valid", 32'(rdata_valid), 32'h1);
        apply_stimulus(1'b1, 1'b1, A_LEDR, 32'h0);
        check_output("rdwr_old_value", rdata, 32'h3FF);
        check_output("rdwr_ledr_cleared", 32'(ledr), 32'h0);

        $display("[TB] decode");
        check_hit("hit_hex", A_HEX, 1'b1);
        check_hit("hit_key", A_KEY, 1'b1);
        check_hit("hit_sw", A_SW, 1'b1);
        check_hit("hit_unaligned", 32'hF000_0001, 1'b0);
        check_hit("hit_unmapped", A_NONE, 1'b0);

        $display("[TB] switch debounce");
        sw = 10'h155;
        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(1'b0, 1'b1, A_SW, '0);
            check_output("sw_debounce", rdata, (k < 7) ? 32'h0 : 32'h155);
        end
        sw = 10'h154;
        apply_stimulus(1'b0, 1'b1, A_SW, '0);
        apply_stimulus(1'b0, 1'b1, A_SW, '0);
        sw = 10'h155;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b1, A_SW, '0);
            check_output("sw_glitch", rdata, 32'h155);
        end
        apply_stimulus(1'b1, 1'b0, A_SW, 32'h0);
        apply_stimulus(1'b0, 1'b1, A_SW, '0);
        check_output("sw_write_ignored", rdata, 32'h155);

        $display("[TB] key debounce");
        key = 4'b1110;
        apply_stimulus(1'b0, 1'b1, A_KEY, '0);
        check_output("key_early", rdata, 32'h0);
        repeat (9) apply_stimulus(1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b0, 1'b1, A_KEY, '0);
        check_output("key0_pressed", rdata, 32'h1);

        $display("[TB] unmapped access");
        apply_stimulus(1'b1, 1'b0, A_NONE, 32'hFFFF_FFFF);
        check_output("none_ledr", 32'(ledr), 32'h0);
        check_output("none_ledg", 32'(ledg), 32'hFF);
        check_output("none_hex0", 32'(hex0), 32'h0E);
        apply_stimulus(1'b0, 1'b1, A_NONE, '0);
        check_output("none_read", rdata, 32'h0);
        check_output("none_valid", 32'(rdata_valid), 32'h1);

`ifdef MMIO_KEY_EDGE_EN
        $display("[TB] KEYEDGE register");
        check_hit("hit_keyedge", A_KEYEDGE, 1'b1);
        apply_stimulus(1'b1, 1'b0, A_KEYEDGE, 32'hF);
        apply_stimulus(1'b0, 1'b1, A_KEYEDGE, '0);
        check_output("keyedge_cleared", rdata, 32'h0);
        key = 4'hF;
        repeat (10) apply_stimulus(1'b0, 1'b0, '0, '0);
        key = 4'b1011;
        repeat (10) apply_stimulus(1'b0, 1'b0, '0, '0);
        key = 4'hF;
        repeat (10) apply_stimulus(1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b0, 1'b1, A_KEYEDGE, '0);
        check_output("keyedge_key2", rdata, 32'h4);
        apply_stimulus(1'b1, 1'b0, A_KEYEDGE, 32'h4);
        apply_stimulus(1'b0, 1'b1, A_KEYEDGE, '0);
        check_output("keyedge_w1c", rdata, 32'h0);
        key = 4'b1101;
        repeat (5) apply_stimulus(1'b0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 1'b0, A_KEYEDGE, 32'h2);
        apply_stimulus(1'b0, 1'b1, A_KEYEDGE, '0);
        check_output("keyedge_set_wins", rdata, 32'h2);
        apply_stimulus(1'b0, 1'b1, A_KEY, '0);
        check_output("key1_pressed", rdata, 32'h2);
`else
        $display("[TB] KEYEDGE absent");
        check_hit("hit_keyedge_absent", A_KEYEDGE, 1'b0);
        apply_stimulus(1'b0, 1'b1, A_SW, '0);
        apply_stimulus(1'b0, 1'b1, A_KEYEDGE, '0);
        check_output("keyedge_absent_read", rdata, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
